// File: rtl/mc_pkg.sv
// Shared definitions for the motor-command path: the 5-bit command format and
// conversion to and from signed speed levels.
package mc_pkg;

    localparam int LVL_W = 5;
    localparam int CMD_W = 5;

    typedef enum logic [1:0] {
        FORWARD = 2'b00,
        NEUTRAL = 2'b01,
        REVERSE = 2'b10
    } dir_t;

    typedef logic signed [LVL_W-1:0] level_t;
    typedef logic [CMD_W-1:0]        mc_cmd_t;

    // Request payload layout: right motor in the upper half.
    typedef struct packed {
        mc_cmd_t right;
        mc_cmd_t left;
    } cmd_pair_t;

    // FORWARD -> +(p+1), REVERSE -> -(p+1), NEUTRAL and the unused code -> 0.
    function automatic level_t cmd_to_level(input mc_cmd_t cmd);
        level_t mag;
        mag = level_t'({2'b00, cmd[4:2]} + 5'd1);
        case (cmd[1:0])
            FORWARD: return mag;
            REVERSE: return -mag;
            default: return '0;
        endcase
    endfunction

    function automatic mc_cmd_t level_to_cmd(input level_t lvl);
        logic [2:0] p;
        if (lvl == '0) begin
            return {3'b000, NEUTRAL};
        end else if (lvl[LVL_W-1]) begin
            p = 3'(-lvl - 5'sd1);
            return {p, REVERSE};
        end else begin
            p = 3'(lvl - 5'sd1);
            return {p, FORWARD};
        end
    endfunction

endpackage

// File: rtl/mc_slew.sv
// One motor's target/current level pair; current steps toward target by at
// most STEP on each frame tick.
module mc_slew
    import mc_pkg::*;
#(
    parameter int unsigned STEP = 2
) (
    input  logic   CLK,
    input  logic   RST_N,
    input  logic   tick,
    input  logic   load,
    input  level_t target_in,
    input  logic   force_zero,
    output level_t current
);

    localparam logic signed [LVL_W:0] STEP_S = (LVL_W + 1)'(STEP);

    level_t                target;
    level_t                target_nxt;
    level_t                step_lvl;
    logic signed [LVL_W:0] cur_ext;
    logic signed [LVL_W:0] diff;

    // A load on a tick edge is seen by that same tick's step.
    always_comb begin
        target_nxt = load ? target_in : target;
        cur_ext    = {current[LVL_W-1], current};
        diff       = {target_nxt[LVL_W-1], target_nxt} - cur_ext;
        if (diff > STEP_S) begin
            step_lvl = level_t'(cur_ext + STEP_S);
        end else if (diff < -STEP_S) begin
            step_lvl = level_t'(cur_ext - STEP_S);
        end else begin
            step_lvl = target_nxt;
        end
    end

    // NOTE: state updates use non-blocking assignments so both motor
    // instances and the arbiter all sample pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            target  <= '0;
            current <= '0;
        end else if (force_zero) begin
            target  <= '0;
            current <= '0;
        end else begin
            target <= target_nxt;
            if (tick) current <= step_lvl;
        end
    end

endmodule

// File: rtl/mc_cmd_arbiter.sv
// Arbitrates obstacle/navigation motor commands, applies the frame-aligned
// slew limit, emergency stop and a no-command watchdog.
module mc_cmd_arbiter
    import mc_pkg::*;
#(
    parameter int unsigned REFRESH         = 1200000,
    parameter int unsigned STEP            = 2,
    parameter int unsigned TIMEOUT_FRAMES  = 42,
    parameter int unsigned OBS_HOLD_FRAMES = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       ESTOP,
    input  logic       OBS_REQ,
    input  logic [9:0] OBS_CMD,
    output logic       OBS_ACK,
    input  logic       NAV_REQ,
    input  logic [9:0] NAV_CMD,
    output logic       NAV_ACK,
    output logic [4:0] MC1,
    output logic [4:0] MC2,
    output logic       FRAME_TICK,
    output logic       TIMED_OUT
);

    localparam int FR_W  = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_FRAMES + 1);
    localparam int OWN_W = $clog2(OBS_HOLD_FRAMES + 1);

    logic [FR_W-1:0]  frame_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic [OWN_W-1:0] own_cnt;

    logic      tick;
    logic      obs_acc;
    logic      nav_acc;
    logic      accept;
    logic      wd_trip;
    logic      load;
    cmd_pair_t acc_cmd;
    level_t    tgt_left;
    level_t    tgt_right;
    level_t    cur_left;
    level_t    cur_right;

    assign tick = (frame_cnt == FR_W'(REFRESH - 1));

    // NOTE: every signal here is assigned on every path, so no latch forms.
    always_comb begin
        obs_acc   = OBS_REQ && !ESTOP;
        nav_acc   = NAV_REQ && !OBS_REQ && (own_cnt == '0) && !ESTOP;
        accept    = obs_acc || nav_acc;
        acc_cmd   = obs_acc ? cmd_pair_t'(OBS_CMD) : cmd_pair_t'(NAV_CMD);
        wd_trip   = tick && !accept && !ESTOP
                    && (wd_cnt == WD_W'(TIMEOUT_FRAMES - 1));
        load      = accept || wd_trip;
        tgt_left  = accept ? cmd_to_level(acc_cmd.left)  : '0;
        tgt_right = accept ? cmd_to_level(acc_cmd.right) : '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_cnt  <= '0;
            FRAME_TICK <= 1'b0;
            OBS_ACK    <= 1'b0;
            NAV_ACK    <= 1'b0;
            wd_cnt     <= '0;
            TIMED_OUT  <= 1'b1;
            own_cnt    <= '0;
        end else begin
            frame_cnt  <= tick ? '0 : frame_cnt + 1'b1;
            FRAME_TICK <= tick;
            // During ESTOP every request is acknowledged and dropped.
            OBS_ACK    <= ESTOP ? OBS_REQ : obs_acc;
            NAV_ACK    <= ESTOP ? NAV_REQ : nav_acc;

            if (ESTOP || accept) begin
                wd_cnt    <= '0;
                TIMED_OUT <= 1'b0;
            end else if (tick && (wd_cnt != WD_W'(TIMEOUT_FRAMES))) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_trip) TIMED_OUT <= 1'b1;
            end

            if (obs_acc) begin
                own_cnt <= OWN_W'(OBS_HOLD_FRAMES);
            end else if (tick && (own_cnt != '0)) begin
                own_cnt <= own_cnt - 1'b1;
            end
        end
    end

    mc_slew #(.STEP(STEP)) u_slew_left (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .tick       (tick),
        .load       (load),
        .target_in  (tgt_left),
        .force_zero (ESTOP),
        .current    (cur_left)
    );

    mc_slew #(.STEP(STEP)) u_slew_right (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .tick       (tick),
        .load       (load),
        .target_in  (tgt_right),
        .force_zero (ESTOP),
        .current    (cur_right)
    );

    assign MC1 = level_to_cmd(cur_left);
    assign MC2 = level_to_cmd(cur_right);

endmodule

// File: doc/mc_cmd_arbiter.md
# mc_cmd_arbiter

Arbitrates motor commands from the obstacle-avoidance and navigation units and slew-limits them. Drives the MC1/MC2 5-bit command inputs of the two-pulse motor-controller PWM generator. Commands change only on a frame tick aligned to the PWM refresh period. An emergency stop forces both motors to neutral immediately. A watchdog ramps both motors to neutral if no command arrives for too long.

## Interface
- REFRESH, 1200000, frame period in CLK cycles (12 ms at 100 MHz)
- STEP, 2, maximum change in signed speed level per motor per frame
- TIMEOUT_FRAMES, 42, frames without an accepted command before the watchdog trips
- OBS_HOLD_FRAMES, 8, frames obstacle ownership persists after the last obstacle accept
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- ESTOP  in  1  level-sensitive emergency stop
- OBS_REQ  in  1  obstacle request; held with OBS_CMD until OBS_ACK
- OBS_CMD  in  10  [4:0] left motor cmd, [9:5] right motor cmd
- OBS_ACK  out  1  one-cycle accept pulse
- NAV_REQ  in  1  navigation request; same handshake
- NAV_CMD  in  10  same layout as OBS_CMD
- NAV_ACK  out  1  one-cycle accept pulse
- MC1  out  5  left motor command to PWM generator
- MC2  out  5  right motor command to PWM generator
- FRAME_TICK  out  1  one-cycle pulse per frame
- TIMED_OUT  out  1  watchdog tripped

## Operation
- Command format: [1:0] direction (00 FORWARD, 01 NEUTRAL, 10 REVERSE), [4:2] power p.
- Signed level L decode: FORWARD → +(p+1); REVERSE → −(p+1); NEUTRAL → 0; 11 → 0. Range −8..+8, stored as 5-bit two's complement.
- Signed level L encode:
  - L>0 → {L−1, 00}.
  - L<0 → {−L−1, 10}.
  - L=0 → 5'b00001.
- Arbitration, at most one accept per cycle:
  - OBS_REQ accepted whenever ESTOP=0.
  - NAV_REQ accepted only when OBS_REQ=0 and obstacle ownership is inactive. Otherwise NAV stalls with no ACK.
  - Ownership is set on each OBS accept and cleared after OBS_HOLD_FRAMES ticks with no OBS accept.
- Accept effects:
  - Both target levels are loaded from the accepted command.
  - The watchdog frame counter clears and TIMED_OUT clears.
- Watchdog: counts ticks since the last accept. On reaching TIMEOUT_FRAMES, both targets go to 0, TIMED_OUT=1, and the counter saturates.
- Slew, on each tick per motor: current moves toward target by min(|target−current|, STEP). A sign crossing passes through arithmetic only; there is no forced dwell at 0.
- ESTOP=1:
  - Current and target are set to 0 on every cycle.
  - Any REQ is ACKed and discarded, so requesters never hang.
  - The watchdog is held cleared.
  - On release, outputs stay neutral until a new command is accepted.

## Timing
- Reset values:
  - MC1 = MC2 = 5'b00001.
  - OBS_ACK = NAV_ACK = 0.
  - FRAME_TICK = 0.
  - TIMED_OUT = 1.
  - Targets, currents, frame counter, watchdog and ownership = 0.
- Frame counter runs 0..REFRESH−1. FRAME_TICK is high for the cycle after the counter reaches REFRESH−1, so the first tick is REFRESH cycles after RST_N deasserts.
- MC1/MC2 update registered on the same edge that raises FRAME_TICK. With no ESTOP they never change at other times.
- ESTOP latency: ESTOP sampled high at edge k → MC1/MC2 = 00001 after edge k, independent of ticks.
- ACK is registered: REQ high at edge k → ACK high for cycle k..k+1 and target loaded at edge k. The requester must drop REQ or present a new CMD after seeing ACK.
- Accept and tick on the same edge: the accepted target is used by that tick's slew step.
- Accept and watchdog expiry on the same tick: the accept wins and TIMED_OUT stays 0.
- RST_N asserted mid-ramp: all state returns to reset values asynchronously.

## Structure
- Shared package mc_pkg holds:
  - direction constants FORWARD/NEUTRAL/REVERSE;
  - level width (5);
  - cmd↔level encode/decode functions, also usable by the PWM generator's testbench.
- Sub-module mc_slew, instantiated twice (one per motor). It holds the current/target registers and the STEP clamp, and has inputs tick, load, target_in and force_zero.

## Test plan
Bench settings: REFRESH=100, STEP=2, TIMEOUT_FRAMES=4, OBS_HOLD_FRAMES=2.
- **Ramp up:** NAV_CMD={5'b11100, 5'b11100} accepted → MC1 goes FORWARD p=1, p=3, p=5, p=7 on four successive ticks, then holds at 5'b11100.
- **Reverse crossing:** from level +8, command {10110, 10110} (level −6) → levels 6, 4, 2, 0, −2, −4, −6 on successive ticks; encoding at 0 is 00001.
- **Priority and ownership:**
  - OBS_REQ and NAV_REQ rise together → OBS_ACK only.
  - NAV stays un-ACKed for 2 ticks after OBS_REQ drops, then NAV_ACK.
- **ESTOP:** at level +8, ESTOP pulses 1 cycle mid-frame → MC1 = MC2 = 00001 the next cycle. A NAV_REQ during ESTOP is ACKed and ignored.
- **Watchdog:**
  - After one command at +4, no requests for 4 ticks → TIMED_OUT=1 and ramp 4→2→0.
  - A new accept clears TIMED_OUT.
- **Reset mid-ramp:** assert RST_N=0 asynchronously at level +6 → MC outputs 00001 immediately and TIMED_OUT=1.
